// File: rtl/vending_pkg.sv
// Shared types for the vending datapath: default product/price widths,
// the lookup FSM state encoding and the "no product" index.
package vending_pkg;

  localparam int N_PRODUCTS_DEF = 10;
  localparam int PRICE_W_DEF    = 8;
  localparam int IDX_W_DEF      = $clog2(N_PRODUCTS_DEF + 1);

  typedef logic [IDX_W_DEF-1:0]   product_idx_t;
  typedef logic [PRICE_W_DEF-1:0] price_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam product_idx_t PRODUCT_NONE = '0;

endpackage

// File: rtl/price_table.sv
// Per-product price register file: synchronous write, combinational read,
// cleared by reset. Products are numbered 1..N_PRODUCTS.
module price_table
  import vending_pkg::*;
#(
  parameter int N_PRODUCTS = 10,
  parameter int PRICE_W    = 8,
  parameter int IDX_W      = $clog2(N_PRODUCTS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [PRICE_W-1:0] wr_price,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [PRICE_W-1:0] rd_price,
  output logic               rd_hit
);

  logic [PRICE_W-1:0] mem_q [1:N_PRODUCTS];

  // Index 0 and anything above N_PRODUCTS match no entry, so such writes drop out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= N_PRODUCTS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 1; i <= N_PRODUCTS; i++) begin
        if (wr_idx == IDX_W'(i)) mem_q[i] <= wr_price;
      end
    end
  end

  always_comb begin
    rd_price = '0;
    rd_hit   = 1'b0;
    for (int i = 1; i <= N_PRODUCTS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_price = mem_q[i];
        rd_hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/price_lookup_unit.sv
// Price lookup engine: writable price table answering one query at a time
// over a valid/ready handshake, with error flagging and shift discount.
module price_lookup_unit
  import vending_pkg::*;
#(
  parameter int N_PRODUCTS = 10,
  parameter int PRICE_W    = 8,
  parameter int IDX_W      = $clog2(N_PRODUCTS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [PRICE_W-1:0] wr_price,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [IDX_W-1:0]   req_product,
  input  logic [1:0]         req_disc,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [PRICE_W-1:0] rsp_price,
  output logic               rsp_err
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   prod_q, prod_d;
  logic [1:0]         disc_q, disc_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic               err_q, err_d;
  logic [PRICE_W-1:0] tbl_price;
  logic               tbl_hit;

  // p - (p >> sh) never underflows since p >> sh <= p.
  function automatic logic [PRICE_W-1:0] apply_disc(input logic [PRICE_W-1:0] p,
                                                    input logic [1:0]         sh);
    return (sh == 2'd0) ? p : p - (p >> sh);
  endfunction

  price_table #(
    .N_PRODUCTS (N_PRODUCTS),
    .PRICE_W    (PRICE_W),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_price (wr_price),
    .rd_idx   (prod_q),
    .rd_price (tbl_price),
    .rd_hit   (tbl_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prod_q  <= IDX_W'(PRODUCT_NONE);
      disc_q  <= '0;
      price_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      disc_q  <= disc_d;
      price_q <= price_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    disc_d  = disc_q;
    price_d = price_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          prod_d  = req_product;
          disc_d  = req_disc;
          state_d = LOOKUP;
        end
      end
      // Table read happens here; a same-cycle write lands only after this edge.
      LOOKUP: begin
        if (!tbl_hit || tbl_price == '0) begin
          price_d = '0;
          err_d   = 1'b1;
        end else begin
          price_d = apply_disc(tbl_price, disc_q);
          err_d   = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_price = price_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_price_lookup_unit.sv
// Scoreboard bench for price_lookup_unit: a price-table model predicts each
// response when the query is driven; responses are popped and compared.
module tb_price_lookup_unit;

  localparam int N  = 10;
  localparam int PW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [PW-1:0] wr_price = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_product = '0;
  logic [1:0]    req_disc = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [PW-1:0] rsp_price;
  logic          rsp_err;

  typedef struct {
    int price;
    int err;
  } rsp_t;

  rsp_t sb_q[$];
  int   model [0:15];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  price_lookup_unit #(.N_PRODUCTS(N), .PRICE_W(PW), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_price    (wr_price),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_product (req_product),
    .req_disc    (req_disc),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_price   (rsp_price),
    .rsp_err     (rsp_err)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic rsp_t model_rsp(input int prod, input int disc);
    rsp_t r;
    int   p;
    p = (prod < 1 || prod > N) ? 0 : model[prod];
    if (p == 0) begin
      r.price = 0;
      r.err   = 1;
    end else begin
      r.price = (disc == 0) ? p : p - (p >> disc);
      r.err   = 0;
    end
    return r;
  endfunction

  task automatic do_write(input int idx, input int price);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_idx   = IW'(idx);
    wr_price = PW'(price);
    if (idx >= 1 && idx <= N) model[idx] = price;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // hold: cycles of rsp_ready=0 in RESP; col_price >= 0 writes the queried
  // product with that price during the LOOKUP cycle.
  task automatic do_query(input int prod, input int disc, input int hold, input int col_price);
    rsp_t exp_r;
    int   t;
    int   held_price;
    int   held_err;
    @(negedge clk);
    check_val("idle_req_ready", int'(req_ready), 1);
    req_valid   = 1'b1;
    req_product = IW'(prod);
    req_disc    = 2'(disc);
    sb_q.push_back(model_rsp(prod, disc));
    @(negedge clk);
    req_valid = 1'b0;
    check_val("lookup_req_ready", int'(req_ready), 0);
    check_val("lookup_rsp_valid", int'(rsp_valid), 0);
    if (col_price >= 0) begin
      wr_en    = 1'b1;
      wr_idx   = IW'(prod);
      wr_price = PW'(col_price);
      model[prod] = col_price;
    end
    rsp_ready = (hold == 0);
    @(negedge clk);
    wr_en = 1'b0;
    check_val("rsp_latency", int'(rsp_valid), 1);
    t = 0;
    while (!rsp_valid && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (rsp_valid) begin
      exp_r = sb_q.pop_front();
      check_val("rsp_price", int'(rsp_price), exp_r.price);
      check_val("rsp_err", int'(rsp_err), exp_r.err);
    end else begin
      check_val("rsp_timeout", 0, 1);
      void'(sb_q.pop_front());
    end
    held_price = int'(rsp_price);
    held_err   = int'(rsp_err);
    for (int k = 0; k < hold; k++) begin
      req_valid   = 1'b1;
      req_product = 4'd1;
      req_disc    = 2'd0;
      @(negedge clk);
      check_val("bp_rsp_valid", int'(rsp_valid), 1);
      check_val("bp_price_stable", int'(rsp_price), held_price);
      check_val("bp_err_stable", int'(rsp_err), held_err);
      check_val("bp_req_ready", int'(req_ready), 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_val("post_hs_rsp_valid", int'(rsp_valid), 0);
    check_val("post_hs_req_ready", int'(req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 0;

    repeat (3) @(negedge clk);
    check_val("rst_req_ready", int'(req_ready), 0);
    check_val("rst_rsp_valid", int'(rsp_valid), 0);
    check_val("rst_rsp_price", int'(rsp_price), 0);
    check_val("rst_rsp_err", int'(rsp_err), 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_req_ready", int'(req_ready), 1);

    do_query(3, 0, 0, -1);

    do_write(1, 50);
    do_write(10, 200);
    do_query(10, 0, 0, -1);
    do_query(1, 1, 0, -1);
    do_query(1, 2, 0, -1);
    do_query(10, 3, 0, -1);

    do_query(0, 0, 0, -1);
    do_query(11, 0, 0, -1);
    do_query(15, 1, 0, -1);
    do_write(0, 99);
    do_write(11, 77);
    for (int i = 1; i <= N; i++) do_query(i, 0, 0, -1);

    do_query(10, 1, 5, -1);

    do_write(2, 40);
    do_query(2, 0, 0, 60);
    do_query(2, 0, 0, -1);

    do_query(10, 0, 0, -1);
    @(negedge clk);
    req_valid   = 1'b1;
    req_product = 4'd10;
    req_disc    = 2'd0;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    check_val("midrst_req_ready_in_rst", int'(req_ready), 0);
    @(negedge clk);
    check_val("midrst_rsp_valid", int'(rsp_valid), 0);
    check_val("midrst_rsp_price", int'(rsp_price), 0);
    check_val("midrst_rsp_err", int'(rsp_err), 0);
    check_val("midrst_req_ready", int'(req_ready), 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 0;
    repeat (3) begin
      @(negedge clk);
      check_val("midrst_no_rsp", int'(rsp_valid), 0);
    end
    do_query(10, 0, 0, -1);
    do_query(1, 0, 0, -1);

    check_val("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
